// File: rtl/s2p_rx.sv
// ============================================================================
// s2p_rx : serial-to-parallel receiver (sck/cs/mosi) with ready/valid output
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module s2p_rx #(
    parameter int WIDTH       = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sck,
    input  logic             cs,
    input  logic             mosi,
    output logic [WIDTH-1:0] out_s2p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SYNC_STAGES-1:0] sck_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sck_prev;
    logic [FILL_W-1:0]      fill;
    logic [WIDTH-1:0]       shreg;
    logic [CNT_W-1:0]       bit_cnt;

    logic             sck_sync;
    logic             cs_sync;
    logic             mosi_sync;
    logic             sck_rise;
    logic             filled;
    logic             shift_en;
    logic             word_done;
    logic [WIDTH-1:0] next_word;

    assign sck_sync  = sck_ff[SYNC_STAGES-1];
    assign cs_sync   = cs_ff[SYNC_STAGES-1];
    assign mosi_sync = mosi_ff[SYNC_STAGES-1];
    assign sck_rise  = sck_sync & ~sck_prev;
    assign filled    = (fill == FILL_W'(SYNC_STAGES));
    assign shift_en  = (state == SHIFT) && !cs_sync && sck_rise;
    assign word_done = shift_en && (bit_cnt == CNT_W'(WIDTH - 1));
    assign next_word = {shreg[WIDTH-2:0], mosi_sync};
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_ff   <= '0;
            cs_ff    <= '1;
            mosi_ff  <= '0;
            sck_prev <= 1'b0;
            fill     <= '0;
        end else begin
            sck_ff   <= {sck_ff[SYNC_STAGES-2:0], sck};
            cs_ff    <= {cs_ff[SYNC_STAGES-2:0], cs};
            mosi_ff  <= {mosi_ff[SYNC_STAGES-2:0], mosi};
            sck_prev <= sck_sync;
            // cs_sync only reflects the pin once the reset-seeded ones have drained
            if (!filled) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ARM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ARM:     if (filled && cs_sync) state_nx = IDLE;
            IDLE:    if (!cs_sync)          state_nx = SHIFT;
            SHIFT:   if (cs_sync)           state_nx = IDLE;
            default:                        state_nx = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            out_s2p   <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (state == SHIFT) && cs_sync && (bit_cnt != '0);
            overrun   <= word_done && out_valid && !out_ready;

            if ((state == IDLE && !cs_sync) || (state == SHIFT && cs_sync)) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= next_word;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end

            // a completing word may replace the current one only if it is taken this cycle
            if (word_done && (!out_valid || out_ready)) begin
                out_s2p   <= next_word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_s2p_rx.sv
// Self-checking bench for s2p_rx: directed frames plus randomized frames
// checked cycle by cycle against a word/event-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_s2p_rx;

    localparam int W  = 14;
    localparam int S  = 2;
    localparam int PH = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         sck = 1'b0;
    logic         cs = 1'b1;
    logic         mosi = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_s2p;
    logic         out_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    s2p_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rstn(rstn), .sck(sck), .cs(cs), .mosi(mosi),
        .out_s2p(out_s2p), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: expected events with due edge ----------------
    typedef struct {
        int           due;
        bit           is_word;
        logic [W-1:0] word;
    } ev_t;
    ev_t evq[$];

    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic         m_fe    = 1'b0;
    logic         m_ov    = 1'b0;
    logic         got_word;
    logic         hshake;
    ev_t          ev;
    int           m_now;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid = 1'b0; m_data = '0; m_fe = 1'b0; m_ov = 1'b0;
            evq.delete();
        end else begin
            m_now    = cyc + 1;
            hshake   = m_valid && out_ready;
            m_fe     = 1'b0;
            m_ov     = 1'b0;
            got_word = 1'b0;
            while (evq.size() > 0 && evq[0].due <= m_now) begin
                ev = evq.pop_front();
                if (ev.is_word) begin
                    got_word = 1'b1;
                    if (!m_valid || out_ready) begin
                        m_data  = ev.word;
                        m_valid = 1'b1;
                    end else begin
                        m_ov = 1'b1;
                    end
                end else begin
                    m_fe = 1'b1;
                end
            end
            if (!got_word && hshake) m_valid = 1'b0;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",     32'(out_valid), 32'(m_valid));
            chk("data",      32'(out_s2p),   32'(m_data));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            chk("overrun",   32'(overrun),   32'(m_ov));
        end
    end

    // observed-event counters used by the directed scenarios
    int           fe_cnt = 0;
    int           ov_cnt = 0;
    int           hs_cnt = 0;
    logic [W-1:0] hsq[$];
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (out_valid && out_ready) begin
            hs_cnt++;
            hsq.push_back(out_s2p);
        end
    end

    // ---------------- consumer ----------------
    bit   ready_rand = 1'b0;
    logic ready_val  = 1'b0;
    int   pulse_at   = -100;
    always @(posedge clk) begin
        #2;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : (ready_val | (cyc == pulse_at));
    end

    // ---------------- serial driver ----------------
    int           nb = 0;
    logic [W-1:0] sr = '0;
    bit           cs_low = 1'b0;
    bit           live = 1'b1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_word, input logic [W-1:0] d);
        ev_t e;
        e.due = cyc + S + 1;
        e.is_word = is_word;
        e.word = d;
        evq.push_back(e);
    endtask

    task automatic sck_bit(input bit b, input int ph, input bit pulse);
        sck = 1'b0; mosi = b;
        tick(ph);
        sck = 1'b1;
        if (cs_low && live) begin
            sr = {sr[W-2:0], b};
            nb++;
            if (nb == W) begin
                push(1'b1, sr);
                nb = 0;
                if (pulse) pulse_at = cyc + S;
            end
        end
        tick(ph);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int ph, input bit pulse);
        for (int i = W - 1; i >= 0; i--) sck_bit(w[i], ph, pulse && (i == 0));
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, input int ph);
        for (int i = W - 1; i > W - 1 - n; i--) sck_bit(w[i], ph, 1'b0);
    endtask

    task automatic cs_fall(input int ph);
        cs = 1'b0; cs_low = 1'b1; nb = 0;
        tick(ph);
    endtask

    task automatic cs_rise(input int ph);
        if (cs_low && live && nb != 0) push(1'b0, '0);
        cs = 1'b1; cs_low = 1'b0; nb = 0; live = 1'b1;
        tick(ph);
    endtask

    task automatic cs_rise_with_sck(input bit b, input int ph);
        sck = 1'b0; mosi = b;
        tick(ph);
        if (cs_low && live && nb != 0) push(1'b0, '0);
        sck = 1'b1; cs = 1'b1; cs_low = 1'b0; nb = 0; live = 1'b1;
        tick(ph);
    endtask

    task automatic drain();
        ready_val = 1'b1; tick(3); ready_val = 1'b0;
    endtask

    int fe0, ov0, hs0, ph, nw, np;

    initial begin
        tick(2);
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_data",   32'(out_s2p),   32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_fe_ov",  32'({frame_err, overrun}), 32'd0);
        rstn = 1'b1;
        chk_en = 1'b1;
        tick(PH);

        // single word, held until taken
        fe0 = fe_cnt; ov0 = ov_cnt;
        cs_fall(PH);
        chk("s1_busy", 32'(busy), 32'd1);
        send_word(14'h2A5C, PH, 1'b0);
        tick(6);
        chk("s1_data",  32'(out_s2p),   32'h2A5C);
        chk("s1_valid", 32'(out_valid), 32'd1);
        cs_rise(PH);
        chk("s1_idle", 32'(busy), 32'd0);
        tick(10);
        chk("s1_hold", 32'(out_valid), 32'd1);
        ready_val = 1'b1; tick(2); ready_val = 1'b0;
        chk("s1_taken", 32'(out_valid), 32'd0);
        chk("s1_no_err", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        // back-to-back words, consumer always ready
        hs0 = hs_cnt; hsq.delete(); ready_val = 1'b1;
        cs_fall(PH);
        send_word(14'h3FFF, PH, 1'b0);
        send_word(14'h0001, PH, 1'b0);
        tick(8);
        cs_rise(PH);
        ready_val = 1'b0;
        chk("s2_count", 32'(hs_cnt - hs0), 32'd2);
        chk("s2_w0", 32'((hsq.size() > 0) ? hsq[0] : 14'h0), 32'h3FFF);
        chk("s2_w1", 32'((hsq.size() > 1) ? hsq[1] : 14'h0), 32'h0001);

        // overrun, then replacement in the handshake cycle
        ov0 = ov_cnt;
        cs_fall(PH);
        send_word(14'h1111, PH, 1'b0);
        send_word(14'h2222, PH, 1'b0);
        chk("s3_keep_first", 32'(out_s2p), 32'h1111);
        chk("s3_ov_once", 32'(ov_cnt - ov0), 32'd1);
        send_word(14'h3333, PH, 1'b1);
        tick(6);
        chk("s3_third", 32'(out_s2p), 32'h3333);
        chk("s3_third_valid", 32'(out_valid), 32'd1);
        chk("s3_no_more_ov", 32'(ov_cnt - ov0), 32'd1);
        cs_rise(PH);
        drain();

        // truncated frame, then a good one
        fe0 = fe_cnt;
        cs_fall(PH);
        send_bits(14'h1FFF, 7, PH);
        cs_rise(PH);
        tick(2);
        chk("s4_fe_once", 32'(fe_cnt - fe0), 32'd1);
        chk("s4_no_valid", 32'(out_valid), 32'd0);
        cs_fall(PH);
        send_word(14'h0ABC, PH, 1'b0);
        tick(4);
        chk("s4_next", 32'(out_s2p), 32'h0ABC);
        cs_rise(PH);
        drain();

        // reset mid-frame: no rejoin until cs has been high
        cs_fall(PH);
        send_bits(14'h2AAA, 5, PH);
        rstn = 1'b0; live = 1'b0; nb = 0;
        tick(2);
        rstn = 1'b1;
        send_word(14'h3FFF, PH, 1'b0);
        send_bits(14'h3FFF, 9, PH);
        chk("s5_no_word", 32'(out_valid), 32'd0);
        chk("s5_not_busy", 32'(busy), 32'd0);
        cs_rise(PH);
        cs_fall(PH);
        send_word(14'h1234, PH, 1'b0);
        tick(4);
        chk("s5_data", 32'(out_s2p), 32'h1234);
        chk("s5_valid", 32'(out_valid), 32'd1);
        cs_rise(PH);
        drain();

        // sck while cs high, then cs rising with the last sck rise
        fe0 = fe_cnt;
        send_word(14'h1555, PH, 1'b0);
        chk("s6_idle_ignored", 32'({busy, out_valid}), 32'd0);
        cs_fall(PH);
        send_bits(14'h2A5C, W - 1, PH);
        cs_rise_with_sck(1'b0, PH);
        tick(2);
        chk("s6_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("s6_no_valid", 32'(out_valid), 32'd0);

        // randomized frames with a random consumer
        ready_rand = 1'b1;
        for (int f = 0; f < 20; f++) begin
            ph = int'($urandom_range(S + 1, S + 3));
            if ($urandom_range(0, 4) == 0) send_word(W'($urandom), ph, 1'b0);
            cs_fall(ph);
            nw = int'($urandom_range(0, 3));
            for (int k = 0; k < nw; k++) send_word(W'($urandom), ph, 1'b0);
            np = int'($urandom_range(0, W - 1));
            if (np == W - 1 && $urandom_range(0, 1) == 1) begin
                send_bits(W'($urandom), W - 1, ph);
                cs_rise_with_sck(1'($urandom_range(0, 1)), ph);
            end else begin
                send_bits(W'($urandom), np, ph);
                cs_rise(ph);
            end
        end
        ready_rand = 1'b0;
        ready_val = 1'b1;
        tick(10);
        chk_en = 1'b0;
        tick(1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/s2p_rx.md
S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 14, word length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flops per input synchronizer, minimum 2.
REQ-003 SHALL have port clk, input, 1, the only clock; all state is updated on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sck, input, 1, serial clock, asynchronous to clk.
REQ-006 SHALL have port cs, input, 1, active-low frame select, asynchronous to clk.
REQ-007 SHALL have port mosi, input, 1, serial data, MSB first, asynchronous to clk.
REQ-008 SHALL have port out_s2p, output, WIDTH, last received word.
REQ-009 SHALL have port out_valid, output, 1, high when out_s2p holds a word the consumer has not yet taken.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the word in any cycle where out_valid=1 and out_ready=1.
REQ-011 SHALL have port busy, output, 1, high in SHIFT state.
REQ-012 SHALL have port frame_err, output, 1, one-clk pulse.
REQ-013 SHALL have port overrun, output, 1, one-clk pulse.

Function
REQ-014 SHALL pass sck, cs and mosi through identical SYNC_STAGES-deep synchronizers, so the three signals keep their relative alignment.
REQ-015 SHALL detect an sck rise as sck_sync=1 while the previous-cycle sck_sync=0; mosi_sync is sampled in that same cycle.
REQ-016 SHALL work correctly when the sck high and low phases are each at least SYNC_STAGES+1 clk periods; behaviour outside this range is undefined.
REQ-017 SHALL use the FSM states ARM, IDLE and SHIFT.
 - ARM: entered on reset; moves to IDLE once cs_sync=1 is seen, so a frame already in progress is never joined mid-frame.
 - IDLE: on cs_sync=0, clear the bit counter and go to SHIFT.
 - SHIFT: on cs_sync=1, return to IDLE.
REQ-018 SHALL, in SHIFT on each sck rise, shift left: shreg <= {shreg[WIDTH-2:0], mosi_sync}, and increment the bit counter.
REQ-019 SHALL, on the sck rise that brings the bit count to WIDTH:
 - load out_s2p with {shreg[WIDTH-2:0], mosi_sync} at that same clk edge;
 - set out_valid=1 at that same clk edge;
 - reset the bit counter to 0, so back-to-back words under one cs low are received continuously.
REQ-020 SHALL hold out_valid and out_s2p stable until a handshake, then clear out_valid in the next cycle unless a new word loads in that same cycle.
REQ-021 SHALL handle a word completing while out_valid=1:
 - with out_ready=1 in that cycle: accept the old word, load the new word, keep out_valid=1, no overrun;
 - with out_ready=0: drop the new word, keep out_s2p unchanged, pulse overrun for one cycle.
REQ-022 SHALL handle cs_sync rising in SHIFT with bit count in 1..WIDTH-1: pulse frame_err for one cycle, discard the partial word, leave out_valid and out_s2p unchanged.
REQ-023 SHALL treat cs_sync rising with bit count 0 as a clean end of frame, with no frame_err.
REQ-024 SHALL ignore an sck rise in the same cycle that cs_sync rises.
REQ-025 SHALL ignore sck activity in IDLE and ARM.
REQ-026 SHALL keep out_s2p registered, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, while rstn=0, immediately drive:
 - all synchronizer flops to 0, except the cs flops to 1;
 - shreg=0, bit counter=0, state=ARM;
 - out_s2p=0, out_valid=0, busy=0, frame_err=0, overrun=0.
REQ-028 SHALL abandon any frame in progress when reset is asserted mid-frame, and SHALL NOT receive again until cs has been seen high.

Verification
REQ-029 SHALL be covered by these directed scenarios (WIDTH=14, sck phases of 4 clk):
 - Single word 14'h2A5C under one cs-low frame -> out_s2p=14'h2A5C, out_valid=1, held until out_ready=1; no frame_err, no overrun.
 - Two back-to-back words 14'h3FFF then 14'h0001 under one cs low, out_ready tied 1 -> two out_valid events, data in that order.
 - Two words with out_ready=0 -> out_s2p=first word, overrun pulses once; then out_ready=1 with a third word in the same cycle -> third word loaded, no overrun.
 - cs raised after 7 bits -> frame_err pulses once; out_valid stays 0; the next full frame receives correctly.
 - rstn pulsed low after 5 bits with cs held low and sck still toggling -> no word is produced until cs goes high then low again; the next frame 14'h1234 is received correctly.
 - cs high with sck toggling, and cs rising simultaneously with the 14th sck rise -> no shifting; the 14th-rise word is reported as frame_err, not as valid.
